decoder_scan_sequencer: RTL and testbench
=========================================

// Module: decoder_scan_sequencer
// PURPOSE
//  Upstream select generator for the 4-to-16 decoder. Steps a 4-bit channel
//  code through the enabled channels of a 16-bit mask, holding each code for
//  DWELL_CYCLES clocks. Runs one frame per start, or repeats frames while
//  continuous=1. sel feeds the decoder input; sel_valid qualifies it.
// PARAMETERS
//  DWELL_CYCLES  4  clocks each enabled channel is held; legal range 1..2**CNT_W
//  CNT_W         8  width of the dwell down-counter
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   synchronous, active-low reset
//  start        in   1   begin a frame; sampled only in IDLE
//  stop         in   1   abort the frame; has priority over start
//  continuous   in   1   1 = start a new frame automatically after DONE
//  mask         in   16  bit i = 1 enables channel i; read live at every search
//  sel          out  4   channel code driven to the decoder input
//  sel_valid    out  1   sel is a live channel
//  busy         out  1   state != IDLE
//  frame_done   out  1   1-cycle pulse, high exactly while in DONE
// BEHAVIOUR
//  Reset: rst_n low at a clock edge -> state IDLE.
//   - sel=0, sel_valid=0, busy=0, frame_done=0, dwell counter=0.
//   - Reset wins over every other input, mid-frame included.
//  States: IDLE, SEEK, DWELL, DONE. Outputs are registered or decoded from the
//   state register; no combinational path from inputs to outputs.
//  IDLE:
//   - start=1, stop=0, mask!=0 -> SEEK.
//   - start with mask==0 -> ignored; stay IDLE.
//   - start and stop in the same cycle -> stay IDLE.
//  SEEK (1 cycle): search for the lowest set mask bit, index >= 0.
//   - Found: load sel=index, sel_valid=1, counter=DWELL_CYCLES-1 -> DWELL.
//   - None (mask cleared meanwhile) -> DONE.
//  DWELL:
//   - counter!=0: decrement; hold sel and sel_valid.
//   - counter==0: search for the lowest set mask bit with index > sel.
//     Found: sel=next, reload counter, stay in DWELL. There is no gap, so
//     sel_valid stays high across channels. None: sel_valid=0 -> DONE.
//  DONE (1 cycle): frame_done=1.
//   - continuous=1 and mask!=0 -> SEEK.
//   - Otherwise -> IDLE.
//  stop=1 in SEEK, DWELL or DONE -> IDLE on the next edge.
//   - sel_valid=0; no frame_done pulse is produced for an aborted frame.
//  start outside IDLE is ignored.
//  Latency: start sampled at edge E0 -> sel_valid=1 after edge E1.
//   - Each channel is valid for exactly DWELL_CYCLES clocks.
//   - Frame length = DWELL_CYCLES * popcount(mask) valid clocks.
//  Channel order: index 15 is the last channel of a frame; there is no wrap
//   inside a frame. A continuous restart begins again at index 0, leaving
//   2 cycles with sel_valid=0 (DONE, then SEEK).
//  sel holds its last value while sel_valid=0; consumers qualify sel with
//   sel_valid.
//  mask changes mid-frame take effect at the next search only; the channel
//   currently held is never cut short.
// TESTING
//  1. DWELL_CYCLES=4, mask=FFFF, 1-cycle start -> sel_valid rises 2 clocks
//     later and stays high 64 clocks; sel runs 0..15, 4 clocks each;
//     frame_done pulses for 1 clock right after; busy then falls.
//  2. mask=8421, start -> sel = 0, 5, 10, 15, 4 clocks each; sel_valid high
//     16 clocks with no gaps; one frame_done pulse.
//  3. continuous=1, mask=0003 -> repeating 0,0,0,0,1,1,1,1 pattern with a
//     2-clock sel_valid=0 gap; frame_done once per frame.
//  4. stop while sel=3 (mask=FFFF) -> next clock IDLE, sel_valid=0, busy=0,
//     no frame_done; a following start restarts at sel=0.
//  5. start with mask=0000 -> no state change. start and stop together in
//     IDLE -> no state change. mask cleared to 0000 during sel=2 -> DONE
//     after the current dwell, frame_done pulses.
//  6. rst_n low 2 clocks mid-DWELL -> all outputs 0 on the first reset edge;
//     DWELL_CYCLES=1 build -> one channel per clock.

Source files
------------

// File: rtl/decoder_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decoder_scan_sequencer
// Brief    : Steps a 4-bit channel code through the enabled bits of a 16-bit
//            mask, holding each code DWELL_CYCLES clocks, for a 4-to-16 decoder.
// Revision : 1.0  initial release
// ============================================================================
module decoder_scan_sequencer #(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        continuous,
    input  logic [15:0] mask,
    output logic [3:0]  sel,
    output logic        sel_valid,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEEK  = 2'd1,
        S_DWELL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_reload = CNT_W'(DWELL_CYCLES - 1);

    state_t           r_state;
    logic [3:0]       r_sel;
    logic             r_sel_valid;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic [3:0]       w_sel_nxt;
    logic             w_valid_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [4:0]       w_seek_hit;
    logic [4:0]       w_next_hit;

    // Returns {found, index} of the lowest set bit of m at or above 'from'.
    function automatic logic [4:0] f_lowest_from(input logic [15:0] m, input logic [4:0] from);
        logic [4:0] res;
        res = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i] && (5'(i) >= from)) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

    assign w_seek_hit = f_lowest_from(mask, 5'd0);
    assign w_next_hit = f_lowest_from(mask, {1'b0, r_sel} + 5'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_sel_valid;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start && !stop && (mask != 16'd0)) begin
                    w_state_nxt = S_SEEK;
                end
            end
            S_SEEK: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end else if (w_seek_hit[4]) begin
                    w_sel_nxt   = w_seek_hit[3:0];
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = c_reload;
                    w_state_nxt = S_DWELL;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DWELL: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (w_next_hit[4]) begin
                    // Seamless hand-over: sel_valid stays high across channels.
                    w_sel_nxt = w_next_hit[3:0];
                    w_cnt_nxt = c_reload;
                end else begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!stop && continuous && (mask != 16'd0)) begin
                    w_state_nxt = S_SEEK;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sel       <= 4'd0;
            r_sel_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_sel_valid <= w_valid_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign sel        = r_sel;
    assign sel_valid  = r_sel_valid;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_decoder_scan_sequencer
// Brief    : Scoreboard bench for decoder_scan_sequencer (DWELL 4 and DWELL 1).
// Revision : 1.0  initial release
// ============================================================================
module tb_decoder_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, continuous;
    logic [15:0] mask;
    logic [3:0]  sel;
    logic        sel_valid, busy, frame_done;

    logic        start1, stop1, cont1;
    logic [15:0] mask1;
    logic [3:0]  sel1;
    logic        sel_valid1, busy1, frame_done1;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       is_done;
        logic [3:0] ch;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    decoder_scan_sequencer #(.DWELL_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .continuous(continuous), .mask(mask), .sel(sel),
        .sel_valid(sel_valid), .busy(busy), .frame_done(frame_done)
    );

    decoder_scan_sequencer #(.DWELL_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1),
        .continuous(cont1), .mask(mask1), .sel(sel1),
        .sel_valid(sel_valid1), .busy(busy1), .frame_done(frame_done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int inst, input logic is_done, input logic [3:0] ch, input int c);
        exp_t e;
        e.is_done = is_done;
        e.ch      = ch;
        e.cyc     = c;
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic push_sel(input int inst, input logic [3:0] ch, input int c, input int d);
        for (int j = 0; j < d; j++) push(inst, 1'b0, ch, c + j);
    endtask

    // Frame started by a start sampled at the edge after cycle 'base'.
    task automatic push_frame(input int inst, input logic [15:0] m, input int base, input int d);
        int c;
        c = base + 2;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                push_sel(inst, 4'(i), c, d);
                c += d;
            end
        end
        push(inst, 1'b1, 4'd0, c);
    endtask

    task automatic mon(input int inst, input logic [3:0] s, input logic v, input logic d);
        exp_t e;
        int   qs;
        if (v === 1'b1 || d === 1'b1) begin
            qs = (inst == 0) ? q0.size() : q1.size();
            n_tests++;
            if (qs == 0) begin
                n_fail++;
                $display("FAIL dut%0d unexpected output: got sel_valid=%b frame_done=%b sel=%0d at cycle %0d, required no output",
                         inst, v, d, s, cyc);
            end else begin
                e = (inst == 0) ? q0.pop_front() : q1.pop_front();
                if (d !== e.is_done || v === d || (!e.is_done && s !== e.ch) || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL dut%0d output: got sel_valid=%b frame_done=%b sel=%0d at cycle %0d, required %s sel=%0d at cycle %0d",
                             inst, v, d, s, cyc, e.is_done ? "frame_done" : "sel_valid", e.ch, e.cyc);
                end
            end
        end
    endtask

    task automatic wait_cyc(input int target);
        int k;
        k = 0;
        while (cyc < target && k < 1000) begin
            tick(1);
            k++;
        end
        check("wait for cycle", (cyc >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < limit) begin
            tick(1);
            k++;
        end
        check(name, q0.size() + q1.size(), 0);
    endtask

    int c0;

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; mask = 16'h0000;
        start1 = 1'b0; stop1 = 1'b0; cont1 = 1'b0; mask1 = 16'h0000;

        fork
            forever begin
                @(negedge clk);
                mon(0, sel, sel_valid, frame_done);
                mon(1, sel1, sel_valid1, frame_done1);
            end
        join_none

        // Reset state
        tick(2);
        check("reset sel", int'(sel), 0);
        check("reset sel_valid", int'(sel_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset busy dut1", int'(busy1), 0);
        rst_n = 1'b1;
        tick(2);

        // Full mask: 16 channels x 4 clocks
        mask = 16'hFFFF; start = 1'b1; c0 = cyc;
        push_frame(0, 16'hFFFF, c0, 4);
        tick(1); start = 1'b0;
        tick(3);
        check("full frame busy", int'(busy), 1);
        wait_drain("full frame drained", 200);
        tick(1);
        check("full frame busy after", int'(busy), 0);

        // Sparse mask 8421 -> 0,5,10,15
        mask = 16'h8421; start = 1'b1; c0 = cyc;
        push_sel(0, 4'd0, c0 + 2, 4);
        push_sel(0, 4'd5, c0 + 6, 4);
        push_sel(0, 4'd10, c0 + 10, 4);
        push_sel(0, 4'd15, c0 + 14, 4);
        push(0, 1'b1, 4'd0, c0 + 18);
        tick(1); start = 1'b0;
        wait_drain("sparse frame drained", 100);
        tick(1);
        check("sparse busy after", int'(busy), 0);

        // Continuous, mask 0003: frames every 10 clocks
        continuous = 1'b1; mask = 16'h0003; start = 1'b1; c0 = cyc;
        push_frame(0, 16'h0003, c0, 4);
        push_frame(0, 16'h0003, c0 + 10, 4);
        push_frame(0, 16'h0003, c0 + 20, 4);
        tick(1); start = 1'b0;
        wait_cyc(c0 + 25);
        continuous = 1'b0;
        wait_drain("continuous drained", 100);
        tick(1);
        check("continuous busy after", int'(busy), 0);

        // Stop while sel=3
        mask = 16'hFFFF; start = 1'b1; c0 = cyc;
        push_sel(0, 4'd0, c0 + 2, 4);
        push_sel(0, 4'd1, c0 + 6, 4);
        push_sel(0, 4'd2, c0 + 10, 4);
        push_sel(0, 4'd3, c0 + 14, 2);
        tick(1); start = 1'b0;
        wait_cyc(c0 + 15);
        stop = 1'b1;
        tick(1); stop = 1'b0;
        check("stop busy", int'(busy), 0);
        check("stop sel_valid", int'(sel_valid), 0);
        check("stop frame_done", int'(frame_done), 0);
        wait_drain("stop drained", 10);
        tick(3);
        start = 1'b1; c0 = cyc;
        push_frame(0, 16'hFFFF, c0, 4);
        tick(1); start = 1'b0;
        wait_drain("restart drained", 200);
        tick(2);

        // Start with empty mask; start+stop together
        mask = 16'h0000; start = 1'b1;
        tick(1);
        check("empty mask start busy", int'(busy), 0);
        start = 1'b0;
        tick(1);
        check("empty mask start busy later", int'(busy), 0);
        mask = 16'hFFFF; start = 1'b1; stop = 1'b1;
        tick(1);
        check("start+stop busy", int'(busy), 0);
        start = 1'b0; stop = 1'b0;
        tick(2);
        check("start+stop busy later", int'(busy), 0);

        // Mask cleared during sel=2
        start = 1'b1; c0 = cyc;
        push_sel(0, 4'd0, c0 + 2, 4);
        push_sel(0, 4'd1, c0 + 6, 4);
        push_sel(0, 4'd2, c0 + 10, 4);
        push(0, 1'b1, 4'd0, c0 + 14);
        tick(1); start = 1'b0;
        wait_cyc(c0 + 11);
        mask = 16'h0000;
        wait_drain("mask clear drained", 50);
        tick(1);
        check("mask clear busy after", int'(busy), 0);
        mask = 16'hFFFF;

        // Reset mid-dwell
        start = 1'b1; c0 = cyc;
        push_sel(0, 4'd0, c0 + 2, 4);
        push_sel(0, 4'd1, c0 + 6, 2);
        tick(1); start = 1'b0;
        wait_cyc(c0 + 7);
        rst_n = 1'b0;
        tick(1);
        check("mid reset sel", int'(sel), 0);
        check("mid reset sel_valid", int'(sel_valid), 0);
        check("mid reset busy", int'(busy), 0);
        check("mid reset frame_done", int'(frame_done), 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("after reset busy", int'(busy), 0);
        wait_drain("reset drained", 5);

        // DWELL_CYCLES=1: one channel per clock
        mask1 = 16'h8421; start1 = 1'b1; c0 = cyc;
        push_sel(1, 4'd0, c0 + 2, 1);
        push_sel(1, 4'd5, c0 + 3, 1);
        push_sel(1, 4'd10, c0 + 4, 1);
        push_sel(1, 4'd15, c0 + 5, 1);
        push(1, 1'b1, 4'd0, c0 + 6);
        tick(1); start1 = 1'b0;
        wait_drain("dwell1 drained", 50);
        tick(1);
        check("dwell1 busy after", int'(busy1), 0);

        tick(3);
        disable fork;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
